// File: rtl/syn_counter_pkg.sv
// Shared types and helpers for the lab counter blocks.
package syn_counter_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DONE = 1'b1
  } cnt_state_t;

  localparam int unsigned CNT_WIDTH_DEFAULT = 4;

  // Sized for the widest counter; callers truncate to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/bin2gray_reg.sv
// Registered binary-to-Gray conversion; resets to the Gray code of all ones.
module bin2gray_reg
  import syn_counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  logic [WIDTH-1:0] gray_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gray_q <= WIDTH'(bin2gray(32'({WIDTH{1'b1}})));
    end else begin
      gray_q <= WIDTH'(bin2gray(32'(bin)));
    end
  end

  assign gray = gray_q;

endmodule

// File: rtl/syn_down_counter.sv
// Loadable down counter with registered terminal-count pulse and done status.
// Define SYN_DOWN_COUNTER_GRAY_EN to add a registered gray_out port.
module syn_down_counter
  import syn_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = CNT_WIDTH_DEFAULT,
  parameter bit          AUTO_RELOAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
`ifdef SYN_DOWN_COUNTER_GRAY_EN
  output logic [WIDTH-1:0] gray_out,
`endif
  output logic             done
);

  cnt_state_t       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    done_d   = done_q;

    if (load) begin
      cnt_d    = load_val;
      reload_d = load_val;
      if (load_val != '0) begin
        state_d = RUN;
        done_d  = 1'b0;
      end else begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end else if (en && (state_q == RUN)) begin
      if (cnt_q > WIDTH'(1)) begin
        cnt_d = cnt_q - WIDTH'(1);
      end else if (cnt_q == WIDTH'(1)) begin
        cnt_d = '0;
        tc_d  = 1'b1;
        if (!AUTO_RELOAD) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end else if (AUTO_RELOAD) begin
        cnt_d = reload_q;
      end else begin
        // Zero while running in one-shot mode: stop rather than wrap.
        state_d = DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      cnt_q    <= '1;
      reload_q <= '1;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end

  assign out  = cnt_q;
  assign tc   = tc_q;
  assign done = done_q;

`ifdef SYN_DOWN_COUNTER_GRAY_EN
  // Fed from the next count so gray_out lines up with out in the same cycle.
  bin2gray_reg #(
    .WIDTH(WIDTH)
  ) u_gray (
    .clk  (clk),
    .rst  (rst),
    .bin  (cnt_d),
    .gray (gray_out)
  );
`endif

endmodule

// File: tb/tb_syn_down_counter.sv
// Scoreboard bench: auto-reload and one-shot counters driven in parallel against a reference model.
module tb_syn_down_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] out_a, out_o;
  logic         tc_a, tc_o, done_a, done_o;
`ifdef SYN_DOWN_COUNTER_GRAY_EN
  logic [W-1:0] gray_a, gray_o;
`endif

  always #5 clk = ~clk;

  syn_down_counter #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .out      (out_a),
    .tc       (tc_a),
`ifdef SYN_DOWN_COUNTER_GRAY_EN
    .gray_out (gray_a),
`endif
    .done     (done_a)
  );

  syn_down_counter #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut_o (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .out      (out_o),
    .tc       (tc_o),
`ifdef SYN_DOWN_COUNTER_GRAY_EN
    .gray_out (gray_o),
`endif
    .done     (done_o)
  );

  typedef struct {
    int cnt;
    bit tc;
    bit done;
  } exp_t;

  exp_t q_a[$];
  exp_t q_o[$];

  int tests = 0;
  int fails = 0;

  // Reference model state: count value, stored reload, stopped flag.
  int cnt_a, rl_a, cnt_o, rl_o;
  bit stop_a, stop_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit auto_rl, input bit e, input bit l, input int v,
                       inout int cnt, inout int rl, inout bit stop, output bit tc);
    tc = 1'b0;
    if (l) begin
      cnt  = v;
      rl   = v;
      stop = (v == 0);
    end else if (e && !stop) begin
      if (cnt == 0) begin
        if (auto_rl) cnt = rl;
        else stop = 1'b1;
      end else begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          tc = 1'b1;
          if (!auto_rl) stop = 1'b1;
        end
      end
    end
  endtask

  task automatic model_reset();
    cnt_a = 15; rl_a = 15; stop_a = 1'b0;
    cnt_o = 15; rl_o = 15; stop_o = 1'b0;
  endtask

  task automatic step(input bit e, input bit l, input int v);
    bit t;
    @(negedge clk);
    en       = e;
    load     = l;
    load_val = W'(v);
    model(1'b1, e, l, v, cnt_a, rl_a, stop_a, t);
    q_a.push_back('{cnt: cnt_a, tc: t, done: stop_a});
    model(1'b0, e, l, v, cnt_o, rl_o, stop_o, t);
    q_o.push_back('{cnt: cnt_o, tc: t, done: stop_o});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_a"}, 32'(out_a), 32'd15);
    chk({tag, "_tc_a"}, 32'(tc_a), 32'd0);
    chk({tag, "_done_a"}, 32'(done_a), 32'd0);
    chk({tag, "_out_o"}, 32'(out_o), 32'd15);
    chk({tag, "_tc_o"}, 32'(tc_o), 32'd0);
    chk({tag, "_done_o"}, 32'(done_o), 32'd0);
`ifdef SYN_DOWN_COUNTER_GRAY_EN
    chk({tag, "_gray_a"}, 32'(gray_a), 32'd8);
    chk({tag, "_gray_o"}, 32'(gray_o), 32'd8);
`endif
  endtask

  // Monitor: every edge that stimulus accounted for has an expected entry.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("auto_out", 32'(out_a), 32'(e.cnt));
      chk("auto_tc", 32'(tc_a), 32'(e.tc));
      chk("auto_done", 32'(done_a), 32'(e.done));
`ifdef SYN_DOWN_COUNTER_GRAY_EN
      chk("auto_gray", 32'(gray_a), 32'(e.cnt ^ (e.cnt >> 1)));
`endif
    end
    if (q_o.size() > 0) begin
      e = q_o.pop_front();
      chk("oneshot_out", 32'(out_o), 32'(e.cnt));
      chk("oneshot_tc", 32'(tc_o), 32'(e.tc));
      chk("oneshot_done", 32'(done_o), 32'(e.done));
`ifdef SYN_DOWN_COUNTER_GRAY_EN
      chk("oneshot_gray", 32'(gray_o), 32'(e.cnt ^ (e.cnt >> 1)));
`endif
    end
  end

  initial begin
    model_reset();
    // Reset held across an edge
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Free run: 14..0 with tc at 0, then reload to 15
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 0);

    // One-shot path: load 5, count out, idle at 0, restart with 3
    step(1'b0, 1'b1, 5);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 3);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 0);

    // Hold at 9
    step(1'b0, 1'b1, 12);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);

    // Load wins over en
    step(1'b1, 1'b1, 7);
    step(1'b1, 1'b0, 0);

    // Zero load: stuck done, en ignored, then load 2
    step(1'b1, 1'b1, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 2);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0);

    // Async reset between edges at out=6
    step(1'b0, 1'b1, 10);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    en   = 1'b0;
    load = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit e, l;
      int v;
      e = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 9) == 0);
      v = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 15));
      step(e, l, v);
    end

    // Drain scoreboard within a bounded number of edges
    for (int i = 0; i < 10; i++) begin
      if (q_a.size() == 0 && q_o.size() == 0) break;
      @(posedge clk);
      #2;
    end
    chk("queue_a_drained", 32'(q_a.size()), 32'd0);
    chk("queue_o_drained", 32'(q_o.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
